// File: rtl/game_ctrl.sv
// Purpose : Pong game-flow FSM (new game, play, new ball, game over, optional pause)
//           driving the countdown timer handshake, score pulses and the graphics freeze.
// Latency : one cycle from a sampled input to a new state or pulse; gra_still follows the state register.
// Backpressure: none; hit/miss/timer_up are sampled every cycle and button edges are never queued.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   btn[1:0]       paddle buttons (level); a rising edge on either bit is a press
//   pause_btn      pause request (level); only used when GAME_PAUSE_EN is defined
//   hit, miss      1-cycle pulses from the collision logic
//   timer_up       countdown timer reached zero
//   timer_start    1-cycle pulse: reload the countdown timer
//   gra_still      1 while play is not live
//   d_inc, d_clr   1-cycle pulses to the score counter
//   balls_left     remaining balls
//   state          0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 OVER, 4 PAUSE
//
// Optional feature macro: GAME_PAUSE_EN (adds the PAUSE state).

module game_ctrl #(
    parameter int LIVES  = 3,
    parameter int BALL_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        btn,
    input  logic              pause_btn,
    input  logic              hit,
    input  logic              miss,
    input  logic              timer_up,
    output logic              timer_start,
    output logic              gra_still,
    output logic              d_inc,
    output logic              d_clr,
    output logic [BALL_W-1:0] balls_left,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        NEWGAME = 3'd0,
        PLAY    = 3'd1,
        NEWBALL = 3'd2,
        OVER    = 3'd3,
        PAUSE   = 3'd4
    } state_t;

    state_t            state_q, state_n;
    logic [BALL_W-1:0] balls_q, balls_n;
    logic              timer_start_q, timer_start_n;
    logic              d_inc_q, d_inc_n;
    logic              d_clr_q, d_clr_n;
    logic [1:0]        btn_d;
    logic              pause_d;
    logic              press;
    logic              pause_press;

    // Rising-edge detect so a held button produces a single press.
    assign press       = |(btn & ~btn_d);
    assign pause_press = pause_btn & ~pause_d;

`ifndef GAME_PAUSE_EN
    // Pause hardware is compiled out; keep the edge detector harmlessly dangling.
    logic unused_pause;
    assign unused_pause = pause_press;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= NEWGAME;
            balls_q       <= BALL_W'(LIVES);
            timer_start_q <= 1'b0;
            d_inc_q       <= 1'b0;
            d_clr_q       <= 1'b0;
            btn_d         <= 2'b00;
            pause_d       <= 1'b0;
        end else begin
            state_q       <= state_n;
            balls_q       <= balls_n;
            timer_start_q <= timer_start_n;
            d_inc_q       <= d_inc_n;
            d_clr_q       <= d_clr_n;
            btn_d         <= btn;
            pause_d       <= pause_btn;
        end
    end

    always_comb begin
        state_n       = state_q;
        balls_n       = balls_q;
        timer_start_n = 1'b0;
        d_inc_n       = 1'b0;
        d_clr_n       = 1'b0;

        case (state_q)
            NEWGAME: begin
                if (press) begin
                    state_n = PLAY;
                    balls_n = BALL_W'(LIVES);
                    d_clr_n = 1'b1;
                end
            end

            PLAY: begin
                // A miss outranks both a simultaneous hit and a pause request.
                if (miss) begin
                    timer_start_n = 1'b1;
                    // "<= 1" rather than "== 1" keeps the counter from wrapping below zero.
                    if (balls_q <= BALL_W'(1)) begin
                        state_n = OVER;
                        balls_n = '0;
                    end else begin
                        state_n = NEWBALL;
                        balls_n = balls_q - BALL_W'(1);
                    end
                end else begin
                    if (hit) begin
                        d_inc_n = 1'b1;
                    end
`ifdef GAME_PAUSE_EN
                    if (pause_press) begin
                        state_n = PAUSE;
                    end
`endif
                end
            end

            // timer_up may still be high from the previous countdown during the
            // reload cycle, so it only counts once timer_start has dropped.
            NEWBALL: begin
                if (timer_up && press && !timer_start_q) begin
                    state_n = PLAY;
                end
            end

            OVER: begin
                if (timer_up && !timer_start_q) begin
                    state_n = NEWGAME;
                end
            end

`ifdef GAME_PAUSE_EN
            PAUSE: begin
                if (pause_press) begin
                    state_n = PLAY;
                end
            end
`endif

            default: begin
                state_n = NEWGAME;
            end
        endcase
    end

    assign timer_start = timer_start_q;
    assign d_inc       = d_inc_q;
    assign d_clr       = d_clr_q;
    assign balls_left  = balls_q;
    assign state       = state_q;
    assign gra_still   = (state_q != PLAY);

endmodule

// File: tb/tb_game_ctrl.sv
// Purpose : self-checking bench for game_ctrl; pulse outputs are checked against a
//           scoreboard of expected cycle numbers, levels are checked inline.
// Inputs are driven 1 time unit after the rising edge; outputs sampled at that point
// or on the falling edge by the pulse monitor.

module tb_game_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] btn = 2'b00;
    logic       pause_btn = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       timer_up = 1'b0;
    logic       timer_start;
    logic       gra_still;
    logic       d_inc;
    logic       d_clr;
    logic [1:0] balls_left;
    logic [2:0] state;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Scoreboard: expected pulse cycles pushed by the tests, observed ones by the monitor.
    int inc_exp[$], inc_obs[$];
    int clr_exp[$], clr_obs[$];
    int ts_exp[$],  ts_obs[$];

    game_ctrl #(.LIVES(3), .BALL_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .pause_btn   (pause_btn),
        .hit         (hit),
        .miss        (miss),
        .timer_up    (timer_up),
        .timer_start (timer_start),
        .gra_still   (gra_still),
        .d_inc       (d_inc),
        .d_clr       (d_clr),
        .balls_left  (balls_left),
        .state       (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (d_inc)       inc_obs.push_back(cyc);
            if (d_clr)       clr_obs.push_back(cyc);
            if (timer_start) ts_obs.push_back(cyc);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        inc_exp.delete(); inc_obs.delete();
        clr_exp.delete(); clr_obs.delete();
        ts_exp.delete();  ts_obs.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        tests++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
        tests++; if (balls_left !== 2'd3) begin fails++; $display("FAIL reset_balls got %0d want 3", balls_left); end
        tests++; if ({timer_start, d_inc, d_clr} !== 3'b000) begin fails++; $display("FAIL reset_pulses got %b want 000", {timer_start, d_inc, d_clr}); end
        tests++; if (gra_still !== 1'b1) begin fails++; $display("FAIL reset_gra_still got %b want 1", gra_still); end
        reset = 1'b0;
        cycle();
        clear_sb();
    endtask

    task automatic test_new_game();
        int e, o;
        clear_sb();
        btn = 2'b01;
        cycle();
        btn = 2'b00;
        clr_exp.push_back(cyc);
        tests++; if (state !== 3'd1) begin fails++; $display("FAIL newgame_state got %0d want 1", state); end
        tests++; if (gra_still !== 1'b0) begin fails++; $display("FAIL newgame_gra_still got %b want 0", gra_still); end
        tests++; if (balls_left !== 2'd3) begin fails++; $display("FAIL newgame_balls got %0d want 3", balls_left); end
        cycle();
        cycle();
        while (clr_exp.size() > 0) begin
            e = clr_exp.pop_front();
            tests++;
            if (clr_obs.size() == 0) begin fails++; $display("FAIL newgame_d_clr got none want cycle %0d", e); end
            else begin
                o = clr_obs.pop_front();
                if (o !== e) begin fails++; $display("FAIL newgame_d_clr got cycle %0d want %0d", o, e); end
            end
        end
        tests++; if (clr_obs.size() != 0) begin fails++; $display("FAIL newgame_d_clr_extra got %0d extra pulses want 0", clr_obs.size()); end
    endtask

    task automatic test_hit();
        int e, o;
        bit moved;
        clear_sb();
        for (int i = 0; i < 3; i++) begin
            hit = 1'b1;
            cycle();
            hit = 1'b0;
            inc_exp.push_back(cyc);
            repeat (i + 1) cycle();
        end
        cycle();
        while (inc_exp.size() > 0) begin
            e = inc_exp.pop_front();
            tests++;
            if (inc_obs.size() == 0) begin fails++; $display("FAIL hit_d_inc got none want cycle %0d", e); end
            else begin
                o = inc_obs.pop_front();
                if (o !== e) begin fails++; $display("FAIL hit_d_inc got cycle %0d want %0d", o, e); end
            end
        end
        tests++; if (inc_obs.size() != 0) begin fails++; $display("FAIL hit_d_inc_extra got %0d extra want 0", inc_obs.size()); end
        moved = 1'b0;
        btn = 2'b11;
        repeat (10) begin
            cycle();
            if (state !== 3'd1) moved = 1'b1;
        end
        btn = 2'b00;
        cycle();
        tests++; if (moved !== 1'b0) begin fails++; $display("FAIL hold_btn_play state left PLAY got %0d want 1", state); end
    endtask

    task automatic test_newball();
        int e, o;
        clear_sb();
        miss = 1'b1;
        cycle();
        miss = 1'b0;
        ts_exp.push_back(cyc);
        tests++; if (state !== 3'd2) begin fails++; $display("FAIL newball_state got %0d want 2", state); end
        tests++; if (balls_left !== 2'd2) begin fails++; $display("FAIL newball_balls got %0d want 2", balls_left); end
        tests++; if (gra_still !== 1'b1) begin fails++; $display("FAIL newball_gra_still got %b want 1", gra_still); end
        cycle();
        btn = 2'b01; cycle(); btn = 2'b00; cycle();
        tests++; if (state !== 3'd2) begin fails++; $display("FAIL newball_early_press got %0d want 2", state); end
        timer_up = 1'b1;
        cycle();
        tests++; if (state !== 3'd2) begin fails++; $display("FAIL newball_press_not_queued got %0d want 2", state); end
        btn = 2'b10; cycle(); btn = 2'b00;
        timer_up = 1'b0;
        tests++; if (state !== 3'd1) begin fails++; $display("FAIL newball_resume got %0d want 1", state); end
        cycle();
        while (ts_exp.size() > 0) begin
            e = ts_exp.pop_front();
            tests++;
            if (ts_obs.size() == 0) begin fails++; $display("FAIL newball_timer_start got none want cycle %0d", e); end
            else begin
                o = ts_obs.pop_front();
                if (o !== e) begin fails++; $display("FAIL newball_timer_start got cycle %0d want %0d", o, e); end
            end
        end
        tests++; if (ts_obs.size() != 0) begin fails++; $display("FAIL newball_timer_start_extra got %0d extra want 0", ts_obs.size()); end
    endtask

    task automatic test_game_over();
        clear_sb();
        // hit and miss together: miss wins, no score
        hit = 1'b1; miss = 1'b1;
        cycle();
        hit = 1'b0; miss = 1'b0;
        tests++; if (balls_left !== 2'd1) begin fails++; $display("FAIL hitmiss_balls got %0d want 1", balls_left); end
        cycle(); cycle();
        tests++; if (inc_obs.size() != 0) begin fails++; $display("FAIL hitmiss_d_inc got %0d pulses want 0", inc_obs.size()); end
        timer_up = 1'b1; cycle();
        btn = 2'b01; cycle(); btn = 2'b00; timer_up = 1'b0;
        cycle();
        miss = 1'b1; cycle(); miss = 1'b0;
        tests++; if (state !== 3'd3) begin fails++; $display("FAIL over_state got %0d want 3", state); end
        tests++; if (balls_left !== 2'd0) begin fails++; $display("FAIL over_balls got %0d want 0", balls_left); end
        tests++; if (timer_start !== 1'b1) begin fails++; $display("FAIL over_timer_start got %b want 1", timer_start); end
        cycle();
        btn = 2'b01; cycle(); btn = 2'b00;
        // hit/miss outside PLAY are ignored
        hit = 1'b1; miss = 1'b1; cycle(); hit = 1'b0; miss = 1'b0;
        tests++; if (state !== 3'd3) begin fails++; $display("FAIL over_ignores_btn got %0d want 3", state); end
        timer_up = 1'b1; cycle(); timer_up = 1'b0;
        tests++; if (state !== 3'd0) begin fails++; $display("FAIL over_exit got %0d want 0", state); end
        tests++; if (balls_left !== 2'd0) begin fails++; $display("FAIL over_exit_balls got %0d want 0", balls_left); end
        cycle();
        tests++; if (inc_obs.size() != 0) begin fails++; $display("FAIL over_no_score got %0d pulses want 0", inc_obs.size()); end
    endtask

    task automatic test_reset_midcount();
        btn = 2'b01; cycle(); btn = 2'b00; cycle();
        miss = 1'b1; cycle(); miss = 1'b0;
        cycle();
        tests++; if (state !== 3'd2) begin fails++; $display("FAIL midcount_setup got %0d want 2", state); end
        reset = 1'b1; cycle(); reset = 1'b0;
        tests++; if (state !== 3'd0) begin fails++; $display("FAIL midcount_reset_state got %0d want 0", state); end
        tests++; if (balls_left !== 2'd3) begin fails++; $display("FAIL midcount_reset_balls got %0d want 3", balls_left); end
        cycle();
    endtask

    task automatic test_stale_timer_up();
        clear_sb();
        timer_up = 1'b1;
        btn = 2'b01; cycle(); btn = 2'b00; cycle();
        for (int b = 3; b > 1; b--) begin
            miss = 1'b1; cycle(); miss = 1'b0;
            // press together with a stale timer_up on the reload cycle must not resume play
            btn = 2'b01; cycle(); btn = 2'b00;
            tests++; if (state !== 3'd2) begin fails++; $display("FAIL stale_newball got %0d want 2", state); end
            cycle();
            btn = 2'b01; cycle(); btn = 2'b00; cycle();
        end
        miss = 1'b1; cycle(); miss = 1'b0;
        cycle();
        tests++; if (state !== 3'd3) begin fails++; $display("FAIL stale_over_hold got %0d want 3", state); end
        cycle();
        tests++; if (state !== 3'd0) begin fails++; $display("FAIL stale_over_exit got %0d want 0", state); end
        timer_up = 1'b0;
        cycle();
    endtask

    task automatic test_pause();
        btn = 2'b01; cycle(); btn = 2'b00; cycle();
        pause_btn = 1'b1; cycle();
`ifdef GAME_PAUSE_EN
        tests++; if (state !== 3'd4) begin fails++; $display("FAIL pause_enter got %0d want 4", state); end
        tests++; if (gra_still !== 1'b1) begin fails++; $display("FAIL pause_gra_still got %b want 1", gra_still); end
        miss = 1'b1; cycle(); miss = 1'b0; cycle();
        tests++; if (balls_left !== 2'd3) begin fails++; $display("FAIL pause_miss_ignored got %0d want 3", balls_left); end
        pause_btn = 1'b0; cycle();
        pause_btn = 1'b1; cycle(); pause_btn = 1'b0;
        tests++; if (state !== 3'd1) begin fails++; $display("FAIL pause_exit got %0d want 1", state); end
`else
        pause_btn = 1'b0;
        tests++; if (state !== 3'd1) begin fails++; $display("FAIL pause_disabled got %0d want 1", state); end
        miss = 1'b1; cycle(); miss = 1'b0;
        tests++; if (balls_left !== 2'd2) begin fails++; $display("FAIL pause_disabled_miss got %0d want 2", balls_left); end
`endif
        cycle();
    endtask

    initial begin
        test_reset();
        test_new_game();
        test_hit();
        test_newball();
        test_game_over();
        test_reset_midcount();
        test_stale_timer_up();
        test_pause();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
